// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the core's SRAM-style port.
// Adds a configurable read latency (RD_LAT) with a registered stall output.
module dmem_responder #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              oe,
  input  logic [3:0]        web,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       di,
  output logic [31:0]       do_data,
  output logic              stall
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Counter counts down from RD_LAT-2, so two bits cover the 1..4 latency range.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [31:0]      r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [1:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_do_data;
  logic             r_stall;

  logic [IDX_W-1:0] w_idx;
  logic             w_accept;
  logic             w_wr;
  logic             w_rd;

  assign w_idx    = addr[IDX_W-1:0];
  assign w_accept = (r_state == S_IDLE) && cs;
  assign w_wr     = w_accept && (web != 4'b1111);
  assign w_rd     = w_accept && oe && (web == 4'b1111);

  generate
    if (ADDR_W > IDX_W) begin : g_addr_wrap
      // Upper address bits are deliberately dropped so addressing wraps.
      logic w_unused_addr;
      assign w_unused_addr = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // NOTE: the storage array has no reset branch; clearing DEPTH words would
  // defeat RAM inference and the contents are undefined after power-up anyway.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!web[i]) r_mem[w_idx][8*i +: 8] <= di[8*i +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_idx     <= '0;
      r_do_data <= 32'h0;
      r_stall   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd) begin
            if (RD_LAT == 1) begin
              r_do_data <= r_mem[w_idx];
            end else begin
              r_idx   <= w_idx;
              r_cnt   <= CNT_INIT;
              r_stall <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Array is sampled at the completing edge; inputs are ignored here.
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_do_data <= r_mem[r_idx];
            r_stall   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign do_data = r_do_data;
  assign stall   = r_stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance per RD_LAT value 1..4,
// each driven by its own request signals, sharing clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        cs_v    [4];
  logic        oe_v    [4];
  logic [3:0]  web_v   [4];
  logic [13:0] addr_v  [4];
  logic [31:0] di_v    [4];
  logic [31:0] do_v    [4];
  logic        stall_v [4];

  int n_checks = 0;
  int n_errors = 0;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_responder #(
        .ADDR_W(14),
        .DEPTH (1024),
        .RD_LAT(g + 1)
      ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs_v[g]),
        .oe     (oe_v[g]),
        .web    (web_v[g]),
        .addr   (addr_v[g]),
        .di     (di_v[g]),
        .do_data(do_v[g]),
        .stall  (stall_v[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int k, input logic [13:0] a, input logic [31:0] d,
                          input logic [3:0] w);
    cs_v[k]   = 1'b1;
    oe_v[k]   = 1'b0;
    web_v[k]  = w;
    addr_v[k] = a;
    di_v[k]   = d;
    tick();
    cs_v[k]   = 1'b0;
    web_v[k]  = 4'hF;
  endtask

  // Issues a read on instance k (latency k+1) and checks stall per cycle and
  // the data at exactly edge k+1 after acceptance.
  task automatic do_read(input int k, input logic [13:0] a, input logic [31:0] exp,
                         input bit move_addr, input string tag);
    int lat;
    lat       = k + 1;
    cs_v[k]   = 1'b1;
    oe_v[k]   = 1'b1;
    web_v[k]  = 4'hF;
    addr_v[k] = a;
    tick();
    if (move_addr && lat > 1) addr_v[k] = 14'h0011;
    else                      cs_v[k]   = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check($sformatf("%s_stall_hi%0d", tag, i), {31'b0, stall_v[k]}, 32'h1);
      tick();
    end
    cs_v[k] = 1'b0;
    check($sformatf("%s_stall_lo", tag), {31'b0, stall_v[k]}, 32'h0);
    check($sformatf("%s_data", tag), do_v[k], exp);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cs_v[k] = 1'b1; oe_v[k] = 1'b1; web_v[k] = 4'hF;
      addr_v[k] = 14'h0; di_v[k] = 32'h0;
    end

    // Reset held with a read request present
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_do%0d", k), do_v[k], 32'h0);
      check($sformatf("rst_stall%0d", k), {31'b0, stall_v[k]}, 32'h0);
    end
    for (int k = 0; k < 4; k++) cs_v[k] = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("idle_do%0d", k), do_v[k], 32'h0);
      check($sformatf("idle_stall%0d", k), {31'b0, stall_v[k]}, 32'h0);
    end

    // Full word then byte-lane stores, RD_LAT=2
    do_write(1, 14'h0010, 32'hDEADBEEF, 4'b0000);
    do_read (1, 14'h0010, 32'hDEADBEEF, 1'b0, "full");
    do_write(1, 14'h0010, 32'h0000AA00, 4'b1101);
    do_read (1, 14'h0010, 32'hDEADAAEF, 1'b0, "lane1");
    do_write(1, 14'h0010, 32'h12340000, 4'b0011);
    do_read (1, 14'h0010, 32'h1234AAEF, 1'b0, "lane23");

    // cs with oe=0 and no write enables is a no-op
    cs_v[1] = 1'b1; oe_v[1] = 1'b0; web_v[1] = 4'hF; addr_v[1] = 14'h0005;
    tick();
    tick();
    cs_v[1] = 1'b0;
    check("noop_do", do_v[1], 32'h1234AAEF);
    check("noop_stall", {31'b0, stall_v[1]}, 32'h0);

    // Address wrap: 0x405 and 0x005 are the same word
    do_write(1, 14'h0405, 32'hCAFEF00D, 4'b0000);
    do_read (1, 14'h0005, 32'hCAFEF00D, 1'b0, "wrap");

    // Back-to-back: request held through completion is accepted again
    cs_v[1] = 1'b1; oe_v[1] = 1'b1; web_v[1] = 4'hF; addr_v[1] = 14'h0010;
    tick();
    check("b2b_stall_a", {31'b0, stall_v[1]}, 32'h1);
    tick();
    check("b2b_stall_b", {31'b0, stall_v[1]}, 32'h0);
    check("b2b_data_b", do_v[1], 32'h1234AAEF);
    tick();
    cs_v[1] = 1'b0;
    check("b2b_stall_c", {31'b0, stall_v[1]}, 32'h1);
    tick();
    check("b2b_stall_d", {31'b0, stall_v[1]}, 32'h0);

    // Latency sweep; address moves to 0x11 during WAIT
    do_write(0, 14'h0010, 32'h11110001, 4'b0000);
    do_write(2, 14'h0010, 32'h33330003, 4'b0000);
    do_write(3, 14'h0010, 32'h44440004, 4'b0000);
    for (int k = 0; k < 4; k++) if (k != 1) do_write(k, 14'h0011, 32'hBAD0BAD0, 4'b0000);
    do_read(0, 14'h0010, 32'h11110001, 1'b0, "lat1");
    do_read(2, 14'h0010, 32'h33330003, 1'b1, "lat3");
    do_read(3, 14'h0010, 32'h44440004, 1'b1, "lat4");

    // Reset one cycle after acceptance aborts the read, RD_LAT=4
    cs_v[3] = 1'b1; oe_v[3] = 1'b1; web_v[3] = 4'hF; addr_v[3] = 14'h0011;
    tick();
    cs_v[3] = 1'b0;
    tick();
    check("abort_pre_stall", {31'b0, stall_v[3]}, 32'h1);
    rst = 1'b0;
    #1;
    check("abort_stall", {31'b0, stall_v[3]}, 32'h0);
    check("abort_do", do_v[3], 32'h0);
    tick();
    check("abort_hold_do", do_v[3], 32'h0);
    rst = 1'b1;
    tick();
    do_read(3, 14'h0010, 32'h44440004, 1'b0, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
